// File: rtl/seq_det_pkg.sv
// Shared types and default parameters for the serial pattern detector.
package seq_det_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int           DEF_PAT_W     = 4;
    localparam int           DEF_CNT_W     = 8;
    localparam int           DEF_THRESH    = 3;
    localparam logic [3:0]   DEF_RESET_PAT = 4'b1001;

endpackage

// File: rtl/seq_window.sv
// Serial shift window with fill counter; hit is combinational on the matching beat.
module seq_window #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift,
    input  logic             din,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             hit
);

    localparam int             FW    = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]  FULL  = FW'(PAT_W);
    localparam logic [FW-1:0]  ARMED = FW'(PAT_W - 1);

    // Only the newest PAT_W-1 bits need storing; the full window is {hist, din}.
    logic [PAT_W-2:0] hist;
    logic [FW-1:0]    fill;
    logic [PAT_W-1:0] win;

    assign win = {hist, din};
    assign hit = shift && (fill >= ARMED) && (win == pattern);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist <= '0;
            fill <= '0;
        end else if (clear) begin
            fill <= '0;
        end else if (shift) begin
            hist <= win[PAT_W-2:0];
            if (hit && !overlap)
                fill <= '0;
            else if (fill != FULL)
                fill <= fill + FW'(1);
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Detector control: IDLE/RUN FSM, pattern config, saturating match counter and irq.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int               PAT_W     = DEF_PAT_W,
    parameter int               CNT_W     = DEF_CNT_W,
    parameter int               THRESH    = DEF_THRESH,
    parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(DEF_RESET_PAT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    input  logic             cfg_wr,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             irq,
    input  logic             irq_ack
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

    state_t           state;
    logic [PAT_W-1:0] pattern;
    logic             overlap;
    logic             run;
    logic             enter;
    logic             hit;
    logic             cnt_inc;
    logic             irq_set;

    assign run     = (state == RUN);
    assign busy    = run;
    assign enter   = !run && start && !stop;
    assign cnt_inc = hit && (match_count != CNT_MAX);
    // irq fires only on the transition into THRESH, not while saturated there.
    assign irq_set = cnt_inc && ((match_count + CNT_W'(1)) == THR);

    seq_window #(
        .PAT_W (PAT_W)
    ) u_window (
        .clk     (clk),
        .reset   (reset),
        .clear   (enter),
        .shift   (run && din_valid),
        .din     (din),
        .pattern (pattern),
        .overlap (overlap),
        .hit     (hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pattern     <= RESET_PAT;
            overlap     <= 1'b1;
            match       <= 1'b0;
            match_count <= '0;
            irq         <= 1'b0;
        end else begin
            match <= hit;
            case (state)
                IDLE: begin
                    if (enter) begin
                        state       <= RUN;
                        match_count <= '0;
                    end else if (cfg_wr && !start) begin
                        pattern <= cfg_pattern;
                        overlap <= cfg_overlap;
                    end
                end
                RUN: begin
                    if (stop)
                        state <= IDLE;
                    if (cnt_inc)
                        match_count <= match_count + CNT_W'(1);
                end
                default: state <= IDLE;
            endcase
            if (irq_set)
                irq <= 1'b1;
            else if (irq_ack)
                irq <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl (default build plus a CNT_W=2 build).
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       din, din_valid, cfg_wr, cfg_overlap, start, stop, irq_ack;
    logic [3:0] cfg_pattern;

    logic       busy, match, irq;
    logic [7:0] match_count;
    logic       busy2, match2, irq2;
    logic [1:0] count2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_det_ctrl u_dut (
        .clk (clk), .reset (reset), .din (din), .din_valid (din_valid),
        .cfg_wr (cfg_wr), .cfg_pattern (cfg_pattern), .cfg_overlap (cfg_overlap),
        .start (start), .stop (stop), .busy (busy), .match (match),
        .match_count (match_count), .irq (irq), .irq_ack (irq_ack)
    );

    seq_det_ctrl #(.CNT_W (2)) u_dut2 (
        .clk (clk), .reset (reset), .din (din), .din_valid (din_valid),
        .cfg_wr (cfg_wr), .cfg_pattern (cfg_pattern), .cfg_overlap (cfg_overlap),
        .start (start), .stop (stop), .busy (busy2), .match (match2),
        .match_count (count2), .irq (irq2), .irq_ack (irq_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs seen after a call reflect the inputs applied by the previous call.
    task automatic cyc(input logic v, input logic d, input logic st, input logic sp, input logic ack);
        @(negedge clk);
        din_valid = v; din = d; start = st; stop = sp; irq_ack = ack; cfg_wr = 1'b0;
    endtask

    task automatic cfg(input logic [3:0] p, input logic ov);
        @(negedge clk);
        cfg_wr = 1'b1; cfg_pattern = p; cfg_overlap = ov;
        din_valid = 1'b0; start = 1'b0; stop = 1'b0; irq_ack = 1'b0;
    endtask

    // bits/exp/ackm are MSB-first: bit n-1 is the first beat.
    task automatic run_stream(input string tag, input logic [15:0] bits, input int n,
                              input logic [15:0] exp, input logic [15:0] ackm);
        for (int i = 0; i <= n; i++) begin
            if (i < n) cyc(1'b1, bits[n-1-i], 1'b0, 1'b0, ackm[n-1-i]);
            else       cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (i > 0) check(tag, match, exp[n-i]);
        end
    endtask

    initial begin
        logic [3:0] gap_bits;
        reset = 1'b1; din = 0; din_valid = 0; cfg_wr = 0; cfg_pattern = 4'b0;
        cfg_overlap = 0; start = 0; stop = 0; irq_ack = 0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_match", match, 0);
        check("rst_count", match_count, 0);
        check("rst_irq", irq, 0);
        reset = 1'b0;

        // Overlapping detection with reset pattern 1001
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("start_busy", busy, 1);
        run_stream("ovl", 16'b1001001, 7, 16'b0001001, 16'b0);
        check("ovl_count", match_count, 2);
        check("ovl_irq", irq, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        check("stop_busy", busy, 0);
        run_stream("idle_ign", 16'b1001, 4, 16'b0, 16'b0);
        check("idle_count_hold", match_count, 2);

        // Non-overlapping detection
        cfg(4'b1001, 1'b0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("start_clr_count", match_count, 0);
        run_stream("novl", 16'b1001001, 7, 16'b0001000, 16'b0);
        check("novl_count", match_count, 1);
        cyc(0, 0, 0, 1, 0);

        // Sparse beats with three idle cycles between them
        cfg(4'b1001, 1'b1);
        cyc(0, 0, 1, 0, 0);
        gap_bits = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            cyc(1, gap_bits[3-k], 0, 0, 0);
            for (int g = 0; g < 3; g++) begin
                cyc(0, 0, 0, 0, 0);
                check("gap_match", match, (k == 3 && g == 0));
            end
        end
        check("gap_count", match_count, 1);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("start_in_run_count", match_count, 1);
        check("start_in_run_busy", busy, 1);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0);
        check("stop_wins_busy", busy, 0);

        // Threshold interrupt, set beats a coincident ack, then saturation
        cyc(0, 0, 1, 0, 0);
        run_stream("irq_a", 16'b1001001, 7, 16'b0001001, 16'b0);
        check("irq_pre", irq, 0);
        run_stream("irq_b", 16'b001, 3, 16'b001, 16'b001);
        check("irq_set_wins", irq, 1);
        check("irq_count", match_count, 3);
        check("irq2_set", irq2, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        check("irq_ack_clr", irq, 0);
        run_stream("sat", 16'b001001, 6, 16'b001001, 16'b0);
        check("count_5", match_count, 5);
        check("count2_sat", count2, 3);
        check("irq_no_reset", irq, 0);
        check("irq2_no_reset", irq2, 0);

        // Config writes are ignored while running
        cfg(4'b0110, 1'b1);
        run_stream("cfg_run", 16'b1001, 4, 16'b0001, 16'b0);
        cyc(0, 0, 0, 1, 0);
        cfg(4'b0110, 1'b1);
        cyc(0, 0, 1, 0, 0);
        run_stream("cfg_idle", 16'b0110, 4, 16'b0001, 16'b0);
        check("cfg_idle_count", match_count, 1);

        // Reset mid-pattern aborts detection and restores the reset pattern
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", match_count, 0);
        check("mid_rst_match", match, 0);
        check("mid_rst_irq", irq, 0);
        cyc(1, 0, 0, 0, 0);
        reset = 1'b0;
        cyc(0, 0, 0, 0, 0);
        check("post_rst_match", match, 0);
        check("post_rst_busy", busy, 0);
        cyc(0, 0, 1, 0, 0);
        run_stream("rst_pat", 16'b1001, 4, 16'b0001, 16'b0);
        check("rst_pat_count", match_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter PAT_W, default 4: pattern length in bits (2..8).
REQ-002 Parameter CNT_W, default 8: match counter width.
REQ-003 Parameter THRESH, default 3: match_count value that raises irq (1..2^CNT_W-1).
REQ-004 Parameter RESET_PAT, default 4'b1001: pattern register reset value.
REQ-005 clk  in  1  single clock, rising-edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 din  in  1  serial data bit.
REQ-008 din_valid  in  1  din qualifier; bits with din_valid=0 are ignored.
REQ-009 cfg_wr  in  1  load cfg_pattern/cfg_overlap (IDLE only).
REQ-010 cfg_pattern  in  PAT_W  pattern to detect, MSB = first bit received.
REQ-011 cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
REQ-012 start  in  1  arm detector.
REQ-013 stop  in  1  disarm detector.
REQ-014 busy  out  1  high while in RUN.
REQ-015 match  out  1  one-cycle pulse per detected pattern.
REQ-016 match_count  out  CNT_W  saturating count of matches since last start.
REQ-017 irq  out  1  level interrupt, set at threshold, cleared by irq_ack.
REQ-018 irq_ack  in  1  interrupt acknowledge.

Function
REQ-019 FSM states SHALL be exactly IDLE and RUN; busy SHALL equal (state==RUN).
REQ-020 IDLE->RUN on start=1 with stop=0; RUN->IDLE on stop=1; start and stop together: stop wins, state ends IDLE.
REQ-021 start in RUN SHALL be ignored.
REQ-022 cfg_wr SHALL update pattern/overlap registers only when state==IDLE and start=0 that cycle; otherwise ignored.
REQ-023 On entering RUN, window fill count and match_count SHALL clear to 0; irq is unaffected.
REQ-024 In RUN, each din_valid beat SHALL shift din into a PAT_W-bit window and increment fill count, saturating at PAT_W.
REQ-025 A match occurs on a beat when fill count >= PAT_W-1 before the beat and {window[PAT_W-2:0],din} equals pattern.
REQ-026 match SHALL pulse high the cycle after the matching beat (1-cycle latency), registered.
REQ-027 overlap=1: window retained after match; overlap=0: fill count SHALL clear to 0 on the matching beat.
REQ-028 match_count SHALL increment with the match pulse (same cycle) and saturate at 2^CNT_W-1.
REQ-029 irq SHALL set the cycle match_count becomes THRESH; stays set until irq_ack; set and irq_ack same cycle: set wins.
REQ-030 In IDLE, din/din_valid SHALL be ignored; match_count holds its last value.
REQ-031 A match beat coinciding with stop SHALL still produce the match pulse and count update.

Reset
REQ-032 reset SHALL asynchronously force: state=IDLE, busy=0, match=0, match_count=0, irq=0, fill count=0, window=0, pattern=RESET_PAT, overlap=1.
REQ-033 Reset asserted mid-RUN SHALL abort detection with no further match pulse after release.

Structure
REQ-034 Package seq_det_pkg SHALL hold the state enumeration and default parameter constants.
REQ-035 Sub-module seq_window SHALL contain the shift window, fill counter and comparator; seq_det_ctrl holds FSM, config, counter and irq.

Verification
REQ-036 Pattern 1001, overlap=1, start, stream 1001001 on consecutive beats -> match after bits 4 and 7, match_count=2.
REQ-037 Same stream with overlap=0 -> one match after bit 4, match_count=1.
REQ-038 Stream 1,0,0,1 with din_valid=0 gaps of 3 cycles between beats -> exactly one match, 1 cycle after final beat.
REQ-039 THRESH=3, drive 3 matches -> irq rises with third match; irq_ack same cycle as a fourth-match-free cycle clears irq next cycle; CNT_W=2 with 5 matches -> count holds 3.
REQ-040 cfg_wr pattern 0110 during RUN -> ignored, 1001 still detected; stop, cfg_wr 0110, start -> 0110 detected.
REQ-041 reset pulsed after bits 100 of 1001 -> no match after subsequent 1; all outputs 0, pattern back to 1001.
